// File: rtl/layer_map_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : layer_map_generator_pkg
// Description : Shared definitions for the layer map generator: map width,
//               state encodings, LFSR tap mask and the path-walk helper.
// Revision    : 1.0 - initial release
// ============================================================================
package layer_map_generator_pkg;

    localparam int          MAP_COLS  = 7;
    localparam logic [2:0]  COL_LAST  = 3'd6;

    // Fibonacci taps x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GEN  = 3'd1,
        ST_LOAD = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Next path column: bounce off the edges, otherwise step in the
    // direction chosen by one random bit.
    function automatic logic [2:0] next_path(input logic [2:0] p, input logic dir);
        if (p == 3'd0) begin
            return 3'd1;
        end else if (p == COL_LAST) begin
            return COL_LAST - 3'd1;
        end else begin
            return dir ? (p + 3'd1) : (p - 3'd1);
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/layer_map_generator_lfsr16.sv
`default_nettype none
// ============================================================================
// Module      : lfsr16
// Description : Free-running 16-bit Fibonacci LFSR, shifts toward the MSB and
//               feeds the parity of the tapped bits into bit 0.
// Ports       : clk   - system clock
//               rst   - asynchronous active-low reset (loads SEED)
//               state - current LFSR value
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr16
    import layer_map_generator_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end

endmodule
`default_nettype wire

// File: rtl/layer_map_generator.sv
`default_nettype none
// ============================================================================
// Module      : layer_map_generator
// Description : Procedural source of block-field rows. Each request emits one
//               or more 7-column layers, each with a one-cycle load strobe,
//               and finishes with a one-cycle map_ready pulse. Every layer
//               holds a path block adjacent to the previous path block.
// Ports       : clk          - system clock
//               rst          - asynchronous active-low reset
//               generate_map - request pulse, honoured only when idle
//               layer_map    - block present per column, index 0 = leftmost
//               block_type   - 1 = fragile block (never set without a block)
//               load_layer   - strobe, layer_map/block_type valid with it
//               map_ready    - pulse on the cycle after the last strobe
//               busy         - high whenever a request is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module layer_map_generator
    import layer_map_generator_pkg::*;
#(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          INIT_LAYERS = 8,
    parameter int          START_COL   = 3,
    parameter int          DENSITY     = 1,
    parameter int          GAP_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  generate_map,
    output logic [0:MAP_COLS-1]   layer_map,
    output logic [0:MAP_COLS-1]   block_type,
    output logic                  load_layer,
    output logic                  map_ready,
    output logic                  busy
);

    localparam int         CNT_W      = $clog2(INIT_LAYERS + 1);
    localparam int         GAP_W      = $clog2(GAP_CYCLES + 1);
    localparam logic [2:0] DENSITY_3B = 3'(DENSITY);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [2:0]            path;
    logic                  first_done;
    logic [15:0]           lfsr;

    logic                  start_layer;
    logic [2:0]            next_col;
    logic [0:MAP_COLS-1]   next_map;
    logic [0:MAP_COLS-1]   next_type;
    logic [1:0]            field;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    // Only the opening layer of the initial fill still has the full count
    // loaded before first_done is set; that layer is the fixed start row.
    assign start_layer = !first_done && (cnt == CNT_W'(INIT_LAYERS));

    always_comb begin
        next_col  = path;
        next_map  = '0;
        next_type = '0;
        field     = '0;
        if (start_layer) begin
            next_map[START_COL] = 1'b1;
        end else begin
            next_col = next_path(path, lfsr[0]);
            for (int c = 0; c < MAP_COLS; c++) begin
                field = {lfsr[2*c+2], lfsr[2*c+1]};
                if (3'(c) == next_col) begin
                    next_map[c] = 1'b1;
                end else begin
                    next_map[c]  = ({1'b0, field} < DENSITY_3B);
                    next_type[c] = next_map[c] & lfsr[c+9];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            gap_cnt    <= '0;
            path       <= 3'(START_COL);
            first_done <= 1'b0;
            layer_map  <= '0;
            block_type <= '0;
            load_layer <= 1'b0;
            map_ready  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (generate_map) begin
                        cnt   <= first_done ? CNT_W'(1) : CNT_W'(INIT_LAYERS);
                        busy  <= 1'b1;
                        state <= ST_GEN;
                    end
                end
                ST_GEN: begin
                    // Outputs update together with the strobe and then hold.
                    layer_map  <= next_map;
                    block_type <= next_type;
                    path       <= next_col;
                    load_layer <= 1'b1;
                    state      <= ST_LOAD;
                end
                ST_LOAD: begin
                    load_layer <= 1'b0;
                    cnt        <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        map_ready <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == '0) begin
                        state <= ST_GEN;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    map_ready  <= 1'b0;
                    first_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_map_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_map_generator
// Description : Scoreboard bench for layer_map_generator. Two instances share
//               stimulus: one with default DENSITY, one with DENSITY = 0.
//               Expected layers and timings are predicted when a request is
//               issued and compared by negedge monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_map_generator;

    localparam logic [15:0] SEED        = 16'hACE1;
    localparam int          INIT_LAYERS = 8;
    localparam int          START_COL   = 3;
    localparam int          GAP_CYCLES  = 4;
    localparam int          PERIOD      = GAP_CYCLES + 2;

    typedef struct {
        int unsigned cyc;
        bit          start;
        logic [0:6]  map;
        logic [0:6]  typ;
        logic [0:6]  map0;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        generate_map = 1'b0;
    logic [0:6]  layer_map,  block_type,  layer_map0, block_type0;
    logic        load_layer, map_ready, busy, load_layer0, map_ready0, busy0;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic [15:0] mlfsr;

    exp_t        q[$];
    exp_t        q0[$];
    int unsigned rdy_q[$];
    int unsigned rdy0_q[$];

    int          mp;
    bit          mfirst;
    int unsigned busy_from, busy_to;
    logic [0:6]  last_map, last_typ, last_map0;
    int          prev_pos;
    int          hits0, hits6;

    layer_map_generator #(
        .SEED(SEED), .INIT_LAYERS(INIT_LAYERS), .START_COL(START_COL),
        .DENSITY(1), .GAP_CYCLES(GAP_CYCLES)
    ) u_dut (
        .clk(clk), .rst(rst), .generate_map(generate_map),
        .layer_map(layer_map), .block_type(block_type), .load_layer(load_layer),
        .map_ready(map_ready), .busy(busy)
    );

    layer_map_generator #(
        .SEED(SEED), .INIT_LAYERS(INIT_LAYERS), .START_COL(START_COL),
        .DENSITY(0), .GAP_CYCLES(GAP_CYCLES)
    ) u_dut0 (
        .clk(clk), .rst(rst), .generate_map(generate_map),
        .layer_map(layer_map0), .block_type(block_type0), .load_layer(load_layer0),
        .map_ready(map_ready0), .busy(busy0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference pseudo-random sequence: polynomial x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) mlfsr <= SEED;
        else      mlfsr <= step(mlfsr);
    end

    function automatic void ref_layer(input logic [15:0] l, input int p, input bit start,
                                      input int dens, output logic [0:6] m,
                                      output logic [0:6] t, output int pn);
        int f;
        m = '0;
        t = '0;
        if (start) begin
            pn = p;
            m[START_COL] = 1'b1;
            return;
        end
        if (p == 0)      pn = 1;
        else if (p == 6) pn = 5;
        else             pn = l[0] ? p + 1 : p - 1;
        for (int c = 0; c < 7; c++) begin
            if (c == pn) begin
                m[c] = 1'b1;
            end else begin
                f    = int'((l >> (2 * c + 1)) & 16'h3);
                m[c] = (f < dens);
                t[c] = m[c] & l[c+9];
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete(); q0.delete(); rdy_q.delete(); rdy0_q.delete();
        mp        = START_COL;
        mfirst    = 1'b0;
        busy_from = 1;
        busy_to   = 0;
        last_map  = '0;
        last_typ  = '0;
        last_map0 = '0;
        prev_pos  = -1;
    endtask

    // Called at a negedge while the DUT is idle. Predicts every layer of the
    // request from the current reference LFSR value and the issue cycle.
    task automatic issue(input bit hold, output int unsigned ready_cyc);
        int          n;
        int          pn, pn0;
        logic [15:0] l;
        logic [0:6]  m, t, m0, t0;
        bit          st;
        exp_t        e;
        n = mfirst ? 1 : INIT_LAYERS;
        l = mlfsr;
        for (int k = 0; k < n; k++) begin
            for (int a = 0; a < ((k == 0) ? 1 : PERIOD); a++) l = step(l);
            st = !mfirst && (k == 0);
            if (!st && mp == 0) hits0++;
            if (!st && mp == 6) hits6++;
            ref_layer(l, mp, st, 1, m, t, pn);
            ref_layer(l, mp, st, 0, m0, t0, pn0);
            mp      = pn;
            e.cyc   = cyc + 2 + PERIOD * k;
            e.start = st;
            e.map   = m;
            e.typ   = t;
            e.map0  = m0;
            q.push_back(e);
            q0.push_back(e);
        end
        ready_cyc = cyc + 3 + PERIOD * (n - 1);
        rdy_q.push_back(ready_cyc);
        rdy0_q.push_back(ready_cyc);
        busy_from = cyc + 1;
        busy_to   = ready_cyc;
        mfirst    = 1'b1;
        generate_map = 1'b1;
        if (!hold) begin
            @(negedge clk);
            generate_map = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && (q.size() || q0.size() || rdy_q.size() || rdy0_q.size()); i++)
            @(negedge clk);
        if (q.size() || q0.size() || rdy_q.size() || rdy0_q.size()) begin
            checks++;
            errors++;
            $display("FAIL timeout: pending %0d layers %0d ready pulses still outstanding",
                     q.size(), rdy_q.size());
            q.delete(); q0.delete(); rdy_q.delete(); rdy0_q.delete();
        end
    endtask

    // Monitor for the DENSITY = 1 instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("busy", 32'(busy), 32'((cyc >= busy_from) && (cyc <= busy_to)));
            if (load_layer) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got load_layer=1 expected none at cycle %0d", cyc);
                end else begin
                    e = q.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("layer_map", 32'(layer_map), 32'(e.map));
                    chk("block_type", 32'(block_type), 32'(e.typ));
                    last_map = e.map;
                    last_typ = e.typ;
                end
            end else begin
                chk("map_hold", 32'(layer_map), 32'(last_map));
                chk("type_hold", 32'(block_type), 32'(last_typ));
            end
            if (map_ready) begin
                if (rdy_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got map_ready=1 expected none at cycle %0d", cyc);
                end else begin
                    chk("ready_cycle", cyc, rdy_q.pop_front());
                end
            end
        end
    end

    // Monitor for the DENSITY = 0 instance: one-hot walk, no fragile blocks.
    always @(negedge clk) begin
        exp_t e;
        int   pos;
        if (rst) begin
            if (load_layer0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe0: got load_layer=1 expected none at cycle %0d", cyc);
                end else begin
                    e = q0.pop_front();
                    chk("strobe_cycle0", cyc, e.cyc);
                    chk("layer_map0", 32'(layer_map0), 32'(e.map0));
                    chk("block_type0", 32'(block_type0), 32'd0);
                    chk("onehot0", 32'($countones(layer_map0)), 32'd1);
                    pos = -1;
                    for (int c = 0; c < 7; c++) if (layer_map0[c]) pos = c;
                    if (!e.start && prev_pos >= 0)
                        chk("adjacent0", 32'((pos > prev_pos) ? pos - prev_pos : prev_pos - pos), 32'd1);
                    prev_pos  = pos;
                    last_map0 = e.map0;
                end
            end else begin
                chk("map_hold0", 32'(layer_map0), 32'(last_map0));
            end
            if (map_ready0) begin
                if (rdy0_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready0: got map_ready=1 expected none at cycle %0d", cyc);
                end else begin
                    chk("ready_cycle0", cyc, rdy0_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned r;
        int unsigned c0;
        hits0 = 0;
        hits6 = 0;
        model_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_map", 32'(layer_map), 32'd0);
        chk("reset_type", 32'(block_type), 32'd0);
        chk("reset_outputs", 32'({load_layer, map_ready, busy}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Initial fill: 8 layers, the first one at START_COL.
        issue(1'b0, r);
        wait_done();
        repeat (3) @(negedge clk);

        // Follow-up single-layer request.
        issue(1'b0, r);
        wait_done();
        repeat (2) @(negedge clk);

        // Request held high throughout, then a pulse on the first idle cycle.
        issue(1'b1, r);
        for (int i = 0; i < 50 && cyc < r; i++) @(negedge clk);
        generate_map = 1'b0;
        @(negedge clk);
        issue(1'b0, r);
        wait_done();

        // Randomised timing between requests.
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            issue(1'b0, r);
            if ($urandom_range(0, 3) == 0) begin
                generate_map = 1'b1;   // extra pulse while busy must be ignored
                @(negedge clk);
                generate_map = 1'b0;
            end
            wait_done();
        end
        chk("path_hit_col0", 32'(hits0 > 0), 32'd1);
        chk("path_hit_col6", 32'(hits6 > 0), 32'd1);

        // Abort the initial fill during a gap.
        rst = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        issue(1'b0, r);
        c0 = r - 3 - PERIOD * (INIT_LAYERS - 1);
        for (int i = 0; i < 20 && cyc < c0 + 4; i++) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_map", 32'(layer_map), 32'd0);
        chk("abort_type", 32'(block_type), 32'd0);
        chk("abort_outputs", 32'({load_layer, map_ready, busy}), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        issue(1'b0, r);
        wait_done();
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
